frame_strobe_sequencer: RTL and testbench
=========================================

FRAME_STROBE_SEQUENCER -- requirements
Module: frame_strobe_sequencer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, config bits per row per frame.
REQ-003 SHALL have parameter NumberOfRows, default 16, tile rows in the column.
REQ-004 SHALL have parameter ColumnID, default 0, 8-bit column address this instance answers to.
REQ-005 SHALL have a single clock and an asynchronous, active-low reset, as the following two ports.
REQ-006 SHALL have port UserCLK, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port cfg_data, input, 32 bits, configuration word.
REQ-009 SHALL have port cfg_valid, input, 1 bit, cfg_data valid.
REQ-010 SHALL have port cfg_ready, output, 1 bit, word accepted when cfg_valid and cfg_ready are high on a rising edge.
REQ-011 SHALL have port FrameData, output, NumberOfRows*FrameBitsPerRow bits; row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
REQ-012 SHALL have port FrameStrobe, output, MaxFramesPerCol bits, one-hot frame latch strobe driven into the column's top tile.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-014 SHALL have port err, output, 1 bit, sticky header error.
REQ-015 SHALL have port frames_done, output, 16 bits, count of strobes issued, wrapping at 0xFFFF to 0.

Function
REQ-016 SHALL implement states IDLE, LOAD, SKIP and STROBE.
REQ-017 SHALL, in IDLE, treat an accepted word as a header with marker [31:24], column [23:16] and frame index [4:0].
REQ-018 SHALL treat a header as invalid when marker != 8'hFA or frame index >= MaxFramesPerCol: set err, consume the word, stay in IDLE.
REQ-019 SHALL go to LOAD when a valid header has column == ColumnID, and to SKIP for any other column; row counter cleared to 0 in both cases.
REQ-020 SHALL, in LOAD, write each accepted word into FrameData row row_cnt and increment row_cnt; other rows are held.
REQ-021 SHALL, in SKIP, consume words without writing FrameData.
REQ-022 SHALL leave LOAD/SKIP on acceptance of word NumberOfRows-1: LOAD goes to STROBE, SKIP goes to IDLE.
REQ-023 SHALL, in STROBE, drive FrameStrobe[index] high for exactly one cycle, beginning the cycle after the last data word is accepted; all other bits stay 0.
REQ-024 SHALL increment frames_done on the STROBE exit, then return to IDLE.
REQ-025 SHALL hold cfg_ready high in IDLE, LOAD and SKIP, and low in STROBE.
REQ-026 SHALL hold FrameData stable from the STROBE cycle until the next LOAD write.
REQ-027 SHALL hold state, row_cnt and FrameData when cfg_valid is low.
REQ-028 SHALL keep FrameStrobe all-zero outside STROBE.

Reset
REQ-029 SHALL, on resetn low at any time, immediately force: state IDLE, row_cnt 0, FrameData 0, FrameStrobe 0, frames_done 0, err 0, busy 0, cfg_ready 0.
REQ-030 SHALL raise cfg_ready on the first clock edge after resetn deasserts.
REQ-031 SHALL discard a partially loaded frame when reset occurs mid-LOAD, with no strobe issued.
REQ-032 SHALL clear err only by reset.

Configuration
REQ-033 SHALL, when macro FRAME_STROBE_HOLD2_EN is defined, make STROBE last two consecutive cycles with FrameStrobe[index] high and cfg_ready low in both, and increment frames_done once.
REQ-034 SHALL, when FRAME_STROBE_HOLD2_EN is not defined, make STROBE last one cycle.

Verification
REQ-035 SHALL cover: header 0xFA000003 with ColumnID 0, then 16 words 0x1000+r -> FrameData row r = 0x1000+r, FrameStrobe = 0x00008 for 1 cycle the cycle after word 15, frames_done = 1.
REQ-036 SHALL cover: header 0xFA050003 -> 16 words consumed, FrameData unchanged, no strobe, frames_done unchanged.
REQ-037 SHALL cover: header 0xFA000014 (index 20) and header 0x12000001 -> err = 1, state stays IDLE, no strobe.
REQ-038 SHALL cover: resetn pulsed low after 7 LOAD words -> all outputs 0 immediately, no strobe, then a new full frame loads correctly.
REQ-039 SHALL cover: cfg_valid toggled randomly during LOAD, cfg_valid held high during STROBE -> word count still 16, STROBE word not accepted, next word treated as header.
REQ-040 SHALL cover: a build with FRAME_STROBE_HOLD2_EN defined -> FrameStrobe high 2 cycles and frames_done increments by 1.

Source files
------------

// File: rtl/frame_strobe_sequencer.sv
// Column configuration sequencer: header + row words -> frame latch strobe.
// Optional FRAME_STROBE_HOLD2_EN stretches the strobe to two cycles.
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 16,
    parameter int ColumnID        = 0
) (
    input  logic                                      UserCLK,
    input  logic                                      resetn,
    input  logic [31:0]                               cfg_data,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]                FrameStrobe,
    output logic                                      busy,
    output logic                                      err,
    output logic [15:0]                               frames_done
);

    localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);
    localparam logic [5:0] FrameLimit = 6'(MaxFramesPerCol);
    localparam logic [7:0] ColAddr = 8'(ColumnID);
    localparam logic [7:0] Marker = 8'hFA;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SKIP,
        STROBE
    } state_t;

    state_t state;
    state_t state_n;

    logic [RowW-1:0]                             row_cnt;
    logic [4:0]                                  frame_idx;
    logic [NumberOfRows-1:0][FrameBitsPerRow-1:0] rows;
    logic                                        live;
    logic                                        err_q;
    logic [15:0]                                 done_q;

    logic accept;
    logic hdr_ok;
    logic col_hit;
    logic last_word;
    logic strobe_exit;

`ifdef FRAME_STROBE_HOLD2_EN
    logic hold_q;
`endif

    // live keeps cfg_ready low until the first edge after reset release
    assign cfg_ready   = live && (state != STROBE);
    assign accept      = cfg_valid && cfg_ready;
    assign hdr_ok      = (cfg_data[31:24] == Marker) &&
                         ({1'b0, cfg_data[4:0]} < FrameLimit);
    assign col_hit     = (cfg_data[23:16] == ColAddr);
    assign last_word   = (row_cnt == LastRow);

    assign busy        = (state != IDLE);
    assign err         = err_q;
    assign frames_done = done_q;
    assign FrameData   = rows;

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        strobe_exit = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && hdr_ok) begin
                    state_n = col_hit ? LOAD : SKIP;
                end
            end
            LOAD: begin
                if (accept && last_word) begin
                    state_n = STROBE;
                end
            end
            SKIP: begin
                if (accept && last_word) begin
                    state_n = IDLE;
                end
            end
            STROBE: begin
`ifdef FRAME_STROBE_HOLD2_EN
                if (hold_q) begin
                    state_n     = IDLE;
                    strobe_exit = 1'b1;
                end
`else
                state_n     = IDLE;
                strobe_exit = 1'b1;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        FrameStrobe = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            FrameStrobe[i] = (state == STROBE) && (5'(i) == frame_idx);
        end
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            live      <= 1'b0;
            row_cnt   <= '0;
            frame_idx <= '0;
            rows      <= '0;
            err_q     <= 1'b0;
            done_q    <= '0;
        end else begin
            live <= 1'b1;
            if (state == IDLE && accept) begin
                if (!hdr_ok) begin
                    err_q <= 1'b1;
                end else begin
                    row_cnt   <= '0;
                    frame_idx <= cfg_data[4:0];
                end
            end
            if ((state == LOAD || state == SKIP) && accept) begin
                if (state == LOAD) begin
                    rows[row_cnt] <= cfg_data[FrameBitsPerRow-1:0];
                end
                row_cnt <= row_cnt + 1'b1;
            end
            if (strobe_exit) begin
                done_q <= done_q + 16'd1;
            end
        end
    end

`ifdef FRAME_STROBE_HOLD2_EN
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= (state == STROBE) && !hold_q;
        end
    end
`endif

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer (default parameters).
module tb_frame_strobe_sequencer;

    logic         UserCLK;
    logic         resetn;
    logic [31:0]  cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [511:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         err;
    logic [15:0]  frames_done;

    int errors = 0;
    int checks = 0;
    int strobe_cycles = 0;
    int s0;
    int acc;

`ifdef FRAME_STROBE_HOLD2_EN
    localparam int StrobeLen = 2;
`else
    localparam int StrobeLen = 1;
`endif

    frame_strobe_sequencer dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err         (err),
        .frames_done (frames_done)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    always @(negedge UserCLK) begin
        if (|FrameStrobe) strobe_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic row(input string tag, input int r, input logic [31:0] exp);
        chk(tag, FrameData[r*32 +: 32], exp);
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        #1;
        chk("rst_strobe", 32'(FrameStrobe), 0);
        chk("rst_done", 32'(frames_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_data", 32'(|FrameData), 0);
        @(posedge UserCLK);
        @(posedge UserCLK);
        #2 resetn = 1'b1;
        #1 chk("ready_pre_edge", 32'(cfg_ready), 0);
        tick();
        chk("ready_post_edge", 32'(cfg_ready), 1);

        // Frame for this column, index 3
        s0 = strobe_cycles;
        send(32'hFA000003);
        chk("t1_busy", 32'(busy), 1);
        for (int r = 0; r < 16; r++) begin
            chk("t1_nostrobe", 32'(FrameStrobe), 0);
            send(32'h1000 + 32'(r));
        end
        chk("t1_strobe", 32'(FrameStrobe), 32'h8);
        chk("t1_ready_lo", 32'(cfg_ready), 0);
        chk("t1_done_mid", 32'(frames_done), 0);
`ifdef FRAME_STROBE_HOLD2_EN
        tick();
        chk("t1_strobe2", 32'(FrameStrobe), 32'h8);
        chk("t1_ready_lo2", 32'(cfg_ready), 0);
        chk("t1_done_mid2", 32'(frames_done), 0);
`endif
        tick();
        chk("t1_strobe_off", 32'(FrameStrobe), 0);
        chk("t1_done", 32'(frames_done), 1);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_ready_hi", 32'(cfg_ready), 1);
        chk("t1_strobe_len", 32'(strobe_cycles - s0), 32'(StrobeLen));
        row("t1_row0", 0, 32'h1000);
        row("t1_row7", 7, 32'h1007);
        row("t1_row15", 15, 32'h100F);

        // Other column: words consumed, nothing written
        s0 = strobe_cycles;
        send(32'hFA050003);
        chk("t2_busy", 32'(busy), 1);
        for (int r = 0; r < 16; r++) send(32'hBEEF0000 + 32'(r));
        chk("t2_idle", 32'(busy), 0);
        row("t2_row0", 0, 32'h1000);
        row("t2_row15", 15, 32'h100F);
        tick();
        chk("t2_done", 32'(frames_done), 1);
        chk("t2_nostrobe", 32'(strobe_cycles - s0), 0);

        // Bad headers
        s0 = strobe_cycles;
        send(32'hFA000014);
        chk("t3_err_idx", 32'(err), 1);
        chk("t3_idle_idx", 32'(busy), 0);
        send(32'h12000001);
        chk("t3_err_mark", 32'(err), 1);
        chk("t3_idle_mark", 32'(busy), 0);
        tick();
        chk("t3_nostrobe", 32'(strobe_cycles - s0), 0);
        chk("t3_done", 32'(frames_done), 1);

        // Reset after 7 LOAD words
        s0 = strobe_cycles;
        send(32'hFA000001);
        for (int r = 0; r < 7; r++) send(32'h2000 + 32'(r));
        #2 resetn = 1'b0;
        #1;
        chk("t4_strobe", 32'(FrameStrobe), 0);
        chk("t4_done", 32'(frames_done), 0);
        chk("t4_err", 32'(err), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_ready", 32'(cfg_ready), 0);
        chk("t4_data", 32'(|FrameData), 0);
        #2 resetn = 1'b1;
        tick();
        chk("t4_ready_up", 32'(cfg_ready), 1);
        chk("t4_nostrobe", 32'(strobe_cycles - s0), 0);
        send(32'hFA000001);
        for (int r = 0; r < 16; r++) send(32'h3000 + 32'(r));
        chk("t4_strobe_new", 32'(FrameStrobe), 32'h2);
`ifdef FRAME_STROBE_HOLD2_EN
        tick();
`endif
        tick();
        chk("t4_done_new", 32'(frames_done), 1);
        row("t4_row0", 0, 32'h3000);
        row("t4_row6", 6, 32'h3006);
        row("t4_row15", 15, 32'h300F);

        // Random valid gaps, index 19, valid held through STROBE
        send(32'hFA000013);
        acc = 0;
        for (int i = 0; i < 300 && acc < 16; i++) begin
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = 32'h4000 + 32'(acc);
            tick();
            if (cfg_valid) acc++;
        end
        chk("t5_words", 32'(acc), 16);
        cfg_valid = 1'b1;
        cfg_data  = 32'hFA050002;
        #1;
        chk("t5_strobe", 32'(FrameStrobe), 32'h80000);
        chk("t5_ready_lo", 32'(cfg_ready), 0);
`ifdef FRAME_STROBE_HOLD2_EN
        tick();
        chk("t5_strobe2", 32'(FrameStrobe), 32'h80000);
        chk("t5_ready_lo2", 32'(cfg_ready), 0);
`endif
        tick();
        chk("t5_idle", 32'(busy), 0);
        chk("t5_done", 32'(frames_done), 2);
        tick();
        chk("t5_hdr_taken", 32'(busy), 1);
        chk("t5_err", 32'(err), 0);
        cfg_valid = 1'b0;
        row("t5_row0", 0, 32'h4000);
        row("t5_row9", 9, 32'h4009);
        row("t5_row15", 15, 32'h400F);
        for (int r = 0; r < 15; r++) send(32'h5000 + 32'(r));
        chk("t5_skip_mid", 32'(busy), 1);
        send(32'h500F);
        chk("t5_skip_end", 32'(busy), 0);
        row("t5_row3", 3, 32'h4003);
        chk("t5_done_end", 32'(frames_done), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
